// File: rtl/uart_frame_packer.sv
// Packs one CH_NUM x 16-bit sample into a HEADER + data + checksum frame for the UART TX handshake.
// Define UART_PACK_CHKSUM_EN to compute the checksum byte; otherwise it is sent as 8'h00.
module uart_frame_packer #(
    parameter int         CH_NUM = 8,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_NUM*16-1:0]       sample_data,
    input  logic                       sample_vld,
    output logic [(CH_NUM*2+2)*8-1:0]  tx_data,
    output logic                       tx_vld,
    input  logic                       tx_rdy,
    output logic                       busy,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                frame_cnt
);

    localparam int FRAME_BYTES = CH_NUM*2 + 2;
    localparam int FRAME_W     = FRAME_BYTES*8;
    localparam int DATA_BYTES  = CH_NUM*2;
    localparam int IDX_W       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
`ifdef UART_PACK_CHKSUM_EN
        S_CALC   = 3'd1,
`endif
        S_SEND   = 3'd2,
        S_ACCEPT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic [CH_NUM*16-1:0] r_pend_data;
    logic                 r_pend_full;
    logic [FRAME_W-1:0]   r_tx_data;
    logic                 r_tx_vld;
    logic                 r_busy;
    logic [15:0]          r_drop_cnt;
    logic [15:0]          r_frame_cnt;
`ifdef UART_PACK_CHKSUM_EN
    logic [7:0]           r_acc;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           w_byte;
`endif

    logic w_consume;
    logic w_capture;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) return v;
        return v + 16'd1;
    endfunction

    // Header in the top byte, channel 0 high byte next, checksum slot left at zero.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [CH_NUM*16-1:0] s);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[FRAME_W-1 -: 8] = HEADER;
        for (int k = 0; k < CH_NUM; k++) begin
            f[(FRAME_BYTES-3-2*k)*8 +: 16] = s[16*k +: 16];
        end
        return f;
    endfunction

`ifdef UART_PACK_CHKSUM_EN
    function automatic logic [7:0] data_byte(input logic [FRAME_W-1:0] f,
                                             input logic [IDX_W-1:0]   idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (idx == IDX_W'(i)) b = f[(FRAME_BYTES-2-i)*8 +: 8];
        end
        return b;
    endfunction

    assign w_byte = data_byte(r_tx_data, r_idx);
`endif

    assign w_consume = (r_state == S_IDLE) && r_pend_full;
    assign w_capture = sample_vld && (!r_pend_full || w_consume);

    // Pending slot: a sample arriving while IDLE empties the slot is kept, not dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_drop_cnt  <= 16'd0;
        end else if (w_capture) begin
            r_pend_full <= 1'b1;
        end else if (sample_vld) begin
            r_drop_cnt  <= sat_inc16(r_drop_cnt);
        end else if (w_consume) begin
            r_pend_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_pend_data <= sample_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tx_data   <= '0;
            r_tx_vld    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
`ifdef UART_PACK_CHKSUM_EN
            r_acc       <= 8'h00;
            r_idx       <= '0;
`endif
        end else begin
            r_tx_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pend_full) begin
                        r_tx_data <= pack_frame(r_pend_data);
                        r_busy    <= 1'b1;
`ifdef UART_PACK_CHKSUM_EN
                        r_acc     <= 8'h00;
                        r_idx     <= '0;
                        r_state   <= S_CALC;
`else
                        r_state   <= S_SEND;
`endif
                    end
                end
`ifdef UART_PACK_CHKSUM_EN
                S_CALC: begin
                    r_acc <= r_acc + w_byte;
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(DATA_BYTES-1)) begin
                        r_tx_data[7:0] <= r_acc + w_byte;
                        r_state        <= S_SEND;
                    end
                end
`endif
                S_SEND: begin
                    if (tx_rdy) begin
                        r_tx_vld <= 1'b1;
                        r_state  <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (!tx_rdy) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (tx_rdy) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tx_data   <= '0;
                    r_tx_vld    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_frame_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_vld    = r_tx_vld;
    assign busy      = r_busy;
    assign drop_cnt  = r_drop_cnt;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: directed scenarios plus a randomized burst phase, with a UART TX ready model.
module tb_uart_frame_packer;

    localparam int CH = 8;
    localparam int FB = CH*2 + 2;
    localparam int FW = FB*8;
    localparam int SW = CH*16;
`ifdef UART_PACK_CHKSUM_EN
    localparam int LAT = 2*CH + 3;
    localparam bit CK  = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit CK  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sample_data;
    logic          sample_vld;
    logic [FW-1:0] tx_data;
    logic          tx_vld;
    logic          tx_rdy;
    logic          busy;
    logic [15:0]   drop_cnt;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    uart_frame_packer #(.CH_NUM(CH), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_vld(sample_vld),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .busy(busy),
        .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
    );

    int checks = 0, failures = 0;
    int cyc = 0, c0 = 0, viol = 0, rdy_cnt = 0, ctrl_len = 30;
    bit hold_low = 1'b0, prev_vld = 1'b0;
    logic [FW-1:0] rx_q[$];
    int            rx_cyc_q[$];
    logic [SW-1:0] iss_q[$];

    // Reference frame built byte by byte from the channel values.
    function automatic logic [FW-1:0] exp_frame(input logic [SW-1:0] s);
        logic [7:0]    b[FB];
        int            sum;
        logic [FW-1:0] r;
        b[0] = 8'hA5;
        sum  = 0;
        for (int k = 0; k < CH; k++) begin
            b[1+2*k] = s[16*k+8 +: 8];
            b[2+2*k] = s[16*k +: 8];
            sum = sum + int'(b[1+2*k]) + int'(b[2+2*k]);
        end
        b[FB-1] = CK ? 8'(sum % 256) : 8'h00;
        r = '0;
        for (int i = 0; i < FB; i++) r[(FB-1-i)*8 +: 8] = b[i];
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_sample();
        logic [SW-1:0] s;
        for (int i = 0; i < SW/32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; also models the UART TX side: ready drops after a start strobe for ctrl_len cycles.
    task automatic tick();
        prev_vld = (tx_vld === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (prev_vld) rdy_cnt = ctrl_len;
        else if (rdy_cnt > 0) rdy_cnt--;
        tx_rdy = !hold_low && (rdy_cnt == 0);
        if (tx_vld === 1'b1) begin
            if (tx_rdy !== 1'b1) viol++;
            rx_q.push_back(tx_data);
            rx_cyc_q.push_back(cyc);
        end
    endtask

    task automatic send(input logic [SW-1:0] s);
        sample_data = s;
        sample_vld  = 1'b1;
        c0 = cyc;
        iss_q.push_back(s);
        tick();
        sample_vld  = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chkv(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k, quiet;
        k = 0;
        quiet = 0;
        while (quiet < 3 && k < budget) begin
            tick();
            k++;
            quiet = (busy === 1'b0 && tx_rdy === 1'b1) ? quiet + 1 : 0;
        end
        chkv(tag, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        sample_vld = 1'b0;
        hold_low   = 1'b0;
        tick();
        rdy_cnt = 0;
        tx_rdy  = 1'b1;
        chkv({tag, "_vld"},   32'(tx_vld),    32'd0);
        chk ({tag, "_data"},  tx_data,        '0);
        chkv({tag, "_busy"},  32'(busy),      32'd0);
        chkv({tag, "_drop"},  32'(drop_cnt),  32'd0);
        chkv({tag, "_frame"}, 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        rx_q.delete();
        rx_cyc_q.delete();
        iss_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] s, sa, sb, sc;
        int            r, j, matched;

        rst = 1'b1; sample_vld = 1'b0; sample_data = '0; tx_rdy = 1'b1;
        tick();
        do_reset("rst0");

        // Directed frame 0x0102, 0x0304, ... 0x0F10
        for (int k = 0; k < CH; k++) s[16*k +: 16] = {8'(2*k+1), 8'(2*k+2)};
        send(s);
        wait_rx(1, 100, "t1_rx");
        chk ("t1_frame", rx_q[0], exp_frame(s));
        chkv("t1_hdr",   32'(rx_q[0][FW-1 -: 8]), 32'h A5);
        chkv("t1_sum",   32'(rx_q[0][7:0]), CK ? 32'h88 : 32'h00);
        chkv("t1_lat",   32'(rx_cyc_q[0] - c0), 32'(LAT));
        tick();
        chkv("t1_vld_one", 32'(tx_vld), 32'd0);
        tick();
        chkv("t1_rdy_low", 32'(tx_rdy), 32'd0);
        chkv("t1_fcnt",    32'(frame_cnt), 32'd1);
        wait_idle(200, "t1_idle");

        // tx_rdy held low long after the frame is ready
        rx_q.delete(); rx_cyc_q.delete();
        hold_low = 1'b1; tx_rdy = 1'b0;
        sa = rand_sample();
        send(sa);
        repeat (LAT + 50) tick();
        chkv("t2_no_vld", 32'(rx_q.size()), 32'd0);
        chkv("t2_busy",   32'(busy), 32'd1);
        hold_low = 1'b0;
        tick();
        r = cyc;
        chkv("t2_rdy_up", 32'(tx_rdy), 32'd1);
        wait_rx(1, 5, "t2_rx");
        chkv("t2_vld_cyc", 32'(rx_cyc_q[0]), 32'(r + 1));
        chk ("t2_frame",   rx_q[0], exp_frame(sa));
        tick();
        chkv("t2_vld_one", 32'(tx_vld), 32'd0);
        wait_idle(200, "t2_idle");

        // Three strobes two cycles apart: second pends, third drops
        do_reset("rst3");
        sa = rand_sample(); sb = rand_sample(); sc = rand_sample();
        send(sa); tick(); send(sb); tick(); send(sc);
        wait_rx(2, 300, "t3_rx");
        wait_idle(300, "t3_idle");
        chk ("t3_f1",    rx_q[0], exp_frame(sa));
        chk ("t3_f2",    rx_q[1], exp_frame(sb));
        chkv("t3_nrx",   32'(rx_q.size()), 32'd2);
        chkv("t3_drop",  32'(drop_cnt), 32'd1);
        chkv("t3_fcnt",  32'(frame_cnt), 32'd2);

        // Strobe in the same cycle IDLE consumes the pending entry
        do_reset("rst4");
        sa = rand_sample(); sb = rand_sample();
        send(sa);
        chkv("t4_idle_cyc", 32'(busy), 32'd0);
        send(sb);
        wait_rx(2, 300, "t4_rx");
        wait_idle(300, "t4_idle");
        chk ("t4_f1",   rx_q[0], exp_frame(sa));
        chk ("t4_f2",   rx_q[1], exp_frame(sb));
        chkv("t4_drop", 32'(drop_cnt), 32'd0);
        chkv("t4_fcnt", 32'(frame_cnt), 32'd2);

        // Reset right after the load (with a sample pending), then reset during DONE
        do_reset("rst5");
        send(rand_sample());
        send(rand_sample());
        do_reset("rst_mid");
        repeat (LAT + 20) tick();
        chkv("t5a_no_vld", 32'(rx_q.size()), 32'd0);
        chkv("t5a_busy",   32'(busy), 32'd0);
        sa = rand_sample();
        send(sa);
        wait_rx(1, 100, "t5b_rx");
        chk ("t5b_frame", rx_q[0], exp_frame(sa));
        repeat (3) tick();
        chkv("t5b_fcnt", 32'(frame_cnt), 32'd1);
        do_reset("rst_done");
        repeat (40) tick();
        chkv("t5b_no_vld", 32'(rx_q.size()), 32'd0);
        sb = rand_sample();
        send(sb);
        wait_rx(1, 100, "t5c_rx");
        chk ("t5c_frame", rx_q[0], exp_frame(sb));
        chkv("t5c_lat",   32'(rx_cyc_q[0] - c0), 32'(LAT));
        wait_idle(200, "t5c_idle");

        // All channels 0xFFFF
        do_reset("rst6");
        s = '1;
        send(s);
        wait_rx(1, 100, "t6_rx");
        chk ("t6_frame", rx_q[0], exp_frame(s));
        chkv("t6_sum",   32'(rx_q[0][7:0]), CK ? 32'hF0 : 32'h00);
        chkv("t6_lat",   32'(rx_cyc_q[0] - c0), 32'(LAT));
        wait_idle(200, "t6_idle");

        // Random bursts: every frame is an issued sample, in order; sent + dropped = issued
        do_reset("rst7");
        for (int n = 0; n < 40; n++) begin
            ctrl_len = $urandom_range(2, 25);
            send(rand_sample());
            repeat ($urandom_range(0, 30)) tick();
        end
        wait_idle(2000, "t7_idle");
        j = 0;
        matched = 0;
        foreach (rx_q[i]) begin
            while (j < iss_q.size() && exp_frame(iss_q[j]) !== rx_q[i]) j++;
            if (j < iss_q.size()) begin
                matched++;
                j++;
            end
        end
        chkv("t7_match",    32'(matched), 32'(rx_q.size()));
        chkv("t7_conserve", 32'(rx_q.size()) + 32'(drop_cnt), 32'(iss_q.size()));
        chkv("t7_fcnt",     32'(frame_cnt), 32'(rx_q.size()));
        chkv("vld_vs_rdy",  32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_packer.md
# uart_frame_packer

Packs one multi-channel sample into a fixed-length UART frame: header byte, channel data bytes, checksum byte. It drives the TX side of `uart_controller` (`tx_data`/`tx_vld`/`tx_rdy`) and sits between the sample source (ThresholdCutter debug output) and the UART. A one-entry pending register absorbs a sample that arrives while a frame is in flight. Any further sample that arrives while that register is full is dropped and counted.

## Interface

- `CH_NUM`, 8: number of 16-bit channels per sample.
- `HEADER`, 8'hA5: frame start byte.
- `FRAME_BYTES`, derived, CH_NUM*2+2 (18 by default): must equal the controller's `TX_DATA_BYTE_WIDTH`.
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset. The top inverts it for the controller's `rst_n`.
- `sample_data` in CH_NUM*16: channel k occupies bits [16k+15:16k].
- `sample_vld` in 1: one-cycle strobe; `sample_data` is valid in that cycle.
- `tx_data` out FRAME_BYTES*8: frame to the controller; MSB byte is sent first.
- `tx_vld` out 1: one-cycle start strobe to the controller.
- `tx_rdy` in 1: controller ready (high while idle; low during transmission).
- `busy` out 1: FSM is not in IDLE.
- `drop_cnt` out 16: count of dropped samples, saturating at 16'hFFFF.
- `frame_cnt` out 16: count of frames handed to the controller, wraps at 16 bits.

## Operation

- Frame layout, MSB first:
  - `tx_data[top:top-7]` = HEADER.
  - Then for channel 0 to CH_NUM-1: high byte, then low byte.
  - `tx_data[7:0]` = checksum.
- Checksum = sum of the 2*CH_NUM data bytes mod 256. The header is excluded.
- Pending register (`pend_data`, `pend_full`):
  - `sample_vld` with `pend_full`=0 captures the sample and sets `pend_full`.
  - `sample_vld` with `pend_full`=1 drops the sample and increments `drop_cnt` (saturating).
  - If `sample_vld` arrives in the same cycle IDLE consumes the pending entry, the new sample is captured, not dropped.
- FSM states:
  - **IDLE**: if `pend_full`, load the frame register from `pend_data`, clear `pend_full`, zero the accumulator and byte index, and go to CALC.
  - **CALC**: add one data byte per cycle, index 0..2*CH_NUM-1. After the last byte, write the checksum into the frame byte and go to SEND.
  - **SEND**: hold `tx_vld`=0 until `tx_rdy`=1. Then register `tx_vld`<=1 and go to ACCEPT.
  - **ACCEPT**: `tx_vld`<=0. Wait for `tx_rdy`=0, then increment `frame_cnt` and go to DONE.
  - **DONE**: wait for `tx_rdy`=1, then go to IDLE.
- `tx_data` holds stable from leaving CALC until IDLE loads the next frame.
- Unreachable state encodings go to IDLE with reset values.

## Timing

- Reset values:
  - `tx_vld`=0, `tx_data`=0, `busy`=0, `drop_cnt`=0, `frame_cnt`=0.
  - `pend_full`=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately and discards the pending sample. No `tx_vld` is issued afterward until a new sample arrives.
- Latency, with `sample_vld` in cycle 0, idle FSM and `tx_rdy`=1:
  - Capture at the end of cycle 0; IDLE load in cycle 1.
  - CALC in cycles 2..2+2*CH_NUM-1; SEND in cycle 2+2*CH_NUM.
  - `tx_vld` is high in cycle 3+2*CH_NUM (cycle 19 by default).
- `tx_vld` is high for exactly one cycle per frame. It never asserts while `tx_rdy`=0.
- Controller behaviour the handshake relies on:
  - `tx_rdy` drops the cycle after `tx_vld` is sampled.
  - `tx_rdy` returns high at the end of the frame.
- Throughput: at most one frame in flight plus one pending sample.

## Configuration

- `UART_PACK_CHKSUM_EN` defined: checksum computed as above via CALC.
- `UART_PACK_CHKSUM_EN` undefined:
  - The CALC state and accumulator are removed.
  - IDLE goes directly to SEND and `tx_data[7:0]`=8'h00.
  - Latency becomes `tx_vld` in cycle 3.
  - Frame width is unchanged.

## Test plan

- Reset, then channels 0x0102, 0x0304, …, 0x0F10 with one `sample_vld` and `tx_rdy`=1:
  - `tx_data` = A5 01 02 03 … 10 88.
  - `tx_vld` for one cycle at cycle 19.
  - `frame_cnt`=1 after `tx_rdy` drops.
- `tx_rdy` held 0 for 50 cycles after CALC: `tx_vld` stays 0, and pulses once on the first cycle after `tx_rdy` rises.
- Three `sample_vld` strobes 2 cycles apart while frame 1 is in flight:
  - The second sample is sent as frame 2.
  - The third is dropped: `drop_cnt`=1, `frame_cnt`=2 at the end.
- `sample_vld` in the exact cycle IDLE consumes the pending entry: no drop, two frames sent.
- Assert `rst` during CALC and again during DONE:
  - Outputs return to reset values next cycle.
  - No `tx_vld`; the next sample produces a correct frame.
- Without `UART_PACK_CHKSUM_EN`: all channels 0xFFFF give `tx_data` = A5 FF…FF 00, with `tx_vld` at cycle 3.
